// File: rtl/logo_bounce_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : logo_bounce_ctrl                                            |
// | Description: Per-frame motion sequencer for the bouncing screensaver     |
// |              logo. On each accepted frame-start pulse it computes the    |
// |              next top-left position, reflects off the screen edges,      |
// |              advances the palette index on any bounce, and commits the   |
// |              new x/y/colour together in a single clock edge.             |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk_25_175   in   1   pixel clock, the only clock                      |
// |   rst          in   1   asynchronous active-high reset                   |
// |   frame_start  in   1   one-cycle pulse at start of vertical blanking    |
// |   pause        in   1   1 = ignore frame_start (freeze motion)           |
// |   speed        in   3   pixels per frame on each axis, 0 = no motion     |
// |   logo_x       out  10  committed logo left edge                         |
// |   logo_y       out  10  committed logo top edge                          |
// |   color_idx    out  3   committed palette index                          |
// |   update_done  out  1   one-cycle pulse when new values are committed    |
// |   bounce       out  1   pulse with update_done if either axis bounced    |
// |   corner       out  1   pulse with update_done if both axes bounced      |
// |   busy         out  1   high while an update is in flight                |
// +--------------------------------------------------------------------------+
// INIT_X must not exceed H_ACTIVE-LOGO_W and INIT_Y must not exceed
// V_ACTIVE-LOGO_H; the position registers assume an on-screen start.
module logo_bounce_ctrl #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int LOGO_W   = 64,
   parameter int LOGO_H   = 32,
   parameter int INIT_X   = 100,
   parameter int INIT_Y   = 60
) (
   input  logic       clk_25_175,
   input  logic       rst,
   input  logic       frame_start,
   input  logic       pause,
   input  logic [2:0] speed,
   output logic [9:0] logo_x,
   output logic [9:0] logo_y,
   output logic [2:0] color_idx,
   output logic       update_done,
   output logic       bounce,
   output logic       corner,
   output logic       busy
);

   // Right/bottom travel limits for the logo's top-left corner. Kept 11 bits
   // wide so that position + step can never wrap before the comparison.
   localparam logic [10:0] c_max_x  = 11'(H_ACTIVE - LOGO_W);
   localparam logic [10:0] c_max_y  = 11'(V_ACTIVE - LOGO_H);
   localparam logic [9:0]  c_init_x = 10'(INIT_X);
   localparam logic [9:0]  c_init_y = 10'(INIT_Y);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CALC_X = 2'd1,
      ST_CALC_Y = 2'd2,
      ST_COMMIT = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_next_state;

   // Committed (visible) values
   logic [9:0]  r_logo_x;
   logic [9:0]  r_logo_y;
   logic [2:0]  r_color_idx;
   logic        r_update_done;
   logic        r_bounce;
   logic        r_corner;

   // Work registers for the update in flight
   logic [2:0]  r_step;
   logic [9:0]  r_shadow_x;
   logic [9:0]  r_shadow_y;
   logic        r_dir_x;      // 1 = moving right
   logic        r_dir_y;      // 1 = moving down
   logic        r_bx;
   logic        r_by;

   // Shared single-axis datapath: CALC_X and CALC_Y run in different cycles,
   // so one adder/comparator pair serves both axes.
   logic        w_accept;
   logic        w_sel_y;
   logic [9:0]  w_axis_pos;
   logic        w_axis_dir;
   logic [10:0] w_axis_max;
   logic [10:0] w_axis_sum;
   logic [9:0]  w_axis_diff;
   logic        w_hit_hi;
   logic        w_hit_lo;
   logic [9:0]  w_axis_new;
   logic        w_axis_bounce;

   assign w_accept    = frame_start & ~pause;
   assign w_sel_y     = (r_state == ST_CALC_Y);
   assign w_axis_pos  = w_sel_y ? r_logo_y : r_logo_x;
   assign w_axis_dir  = w_sel_y ? r_dir_y  : r_dir_x;
   assign w_axis_max  = w_sel_y ? c_max_y  : c_max_x;
   assign w_axis_sum  = {1'b0, w_axis_pos} + {8'd0, r_step};
   // Only consumed when the position exceeds the step, so it never wraps.
   assign w_axis_diff = w_axis_pos - {7'd0, r_step};
   // Landing exactly on an edge counts as a bounce.
   assign w_hit_hi    = (w_axis_sum >= w_axis_max);
   assign w_hit_lo    = ({1'b0, w_axis_pos} <= {8'd0, r_step});

   // Next position for the selected axis. A zero step never bounces, even
   // when the logo already rests on the edge it is heading towards.
   always_comb begin
      w_axis_new    = w_axis_pos;
      w_axis_bounce = 1'b0;
      if (r_step != 3'd0) begin
         if (w_axis_dir) begin
            if (w_hit_hi) begin
               w_axis_new    = w_axis_max[9:0];
               w_axis_bounce = 1'b1;
            end else begin
               w_axis_new    = w_axis_sum[9:0];
            end
         end else begin
            if (w_hit_lo) begin
               w_axis_new    = 10'd0;
               w_axis_bounce = 1'b1;
            end else begin
               w_axis_new    = w_axis_diff;
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_25_175 or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next-state logic. A frame_start arriving outside IDLE is dropped.
   // ---------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_next_state = ST_CALC_X;
            end
         end
         ST_CALC_X: w_next_state = ST_CALC_Y;
         ST_CALC_Y: w_next_state = ST_COMMIT;
         ST_COMMIT: w_next_state = ST_IDLE;
         default:   w_next_state = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Datapath. Shadow registers decouple the calculation from the visible
   // outputs: logo_x, logo_y and color_idx move together on the COMMIT edge
   // only, so the renderer never sees a half-updated position.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_25_175 or posedge rst) begin
      if (rst) begin
         r_logo_x      <= c_init_x;
         r_logo_y      <= c_init_y;
         r_color_idx   <= 3'd0;
         r_update_done <= 1'b0;
         r_bounce      <= 1'b0;
         r_corner      <= 1'b0;
         r_step        <= 3'd0;
         r_shadow_x    <= c_init_x;
         r_shadow_y    <= c_init_y;
         r_dir_x       <= 1'b1;
         r_dir_y       <= 1'b1;
         r_bx          <= 1'b0;
         r_by          <= 1'b0;
      end else begin
         r_update_done <= 1'b0;
         r_bounce      <= 1'b0;
         r_corner      <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               // speed is sampled only here; later changes cannot disturb
               // the update in flight.
               if (w_accept) begin
                  r_step <= speed;
               end
            end
            ST_CALC_X: begin
               r_shadow_x <= w_axis_new;
               if (w_axis_bounce) begin
                  r_dir_x <= ~r_dir_x;
                  r_bx    <= 1'b1;
               end
            end
            ST_CALC_Y: begin
               r_shadow_y <= w_axis_new;
               if (w_axis_bounce) begin
                  r_dir_y <= ~r_dir_y;
                  r_by    <= 1'b1;
               end
            end
            ST_COMMIT: begin
               r_logo_x      <= r_shadow_x;
               r_logo_y      <= r_shadow_y;
               // A corner still advances the palette by exactly one step.
               if (r_bx | r_by) begin
                  r_color_idx <= r_color_idx + 3'd1;
               end
               r_update_done <= 1'b1;
               r_bounce      <= r_bx | r_by;
               r_corner      <= r_bx & r_by;
               r_bx          <= 1'b0;
               r_by          <= 1'b0;
            end
            default: begin
               r_bx <= 1'b0;
               r_by <= 1'b0;
            end
         endcase
      end
   end

   assign logo_x      = r_logo_x;
   assign logo_y      = r_logo_y;
   assign color_idx   = r_color_idx;
   assign update_done = r_update_done;
   assign bounce      = r_bounce;
   assign corner      = r_corner;
   assign busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_logo_bounce_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : tb_logo_bounce_ctrl                                         |
// | Description: Self-checking bench for logo_bounce_ctrl. Two instances     |
// |              share stimulus: one from the default start position and one |
// |              starting next to the bottom-right corner. A behavioural     |
// |              model predicts every output on every cycle.                 |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_logo_bounce_ctrl;

   localparam int MAX_X = 576;
   localparam int MAX_Y = 448;

   logic       clk = 1'b0;
   logic       rst;
   logic       frame_start;
   logic       pause;
   logic [2:0] speed;

   logic [9:0] a_x, a_y, b_x, b_y;
   logic [2:0] a_c, b_c;
   logic       a_done, a_bnc, a_cor, a_busy;
   logic       b_done, b_bnc, b_cor, b_busy;

   int n_cmp  = 0;
   int n_fail = 0;

   initial forever #5 clk = ~clk;

   logo_bounce_ctrl u_dut_a (
      .clk_25_175 (clk),
      .rst        (rst),
      .frame_start(frame_start),
      .pause      (pause),
      .speed      (speed),
      .logo_x     (a_x),
      .logo_y     (a_y),
      .color_idx  (a_c),
      .update_done(a_done),
      .bounce     (a_bnc),
      .corner     (a_cor),
      .busy       (a_busy)
   );

   logo_bounce_ctrl #(.INIT_X(575), .INIT_Y(447)) u_dut_b (
      .clk_25_175 (clk),
      .rst        (rst),
      .frame_start(frame_start),
      .pause      (pause),
      .speed      (speed),
      .logo_x     (b_x),
      .logo_y     (b_y),
      .color_idx  (b_c),
      .update_done(b_done),
      .bounce     (b_bnc),
      .corner     (b_cor),
      .busy       (b_busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // ------------------------------------------------------------------
   // Behavioural model: index 0 = instance a, 1 = instance b.
   // Direction is +1/-1; an accepted frame computes the result at once
   // and it becomes visible four cycles after the frame_start cycle.
   // ------------------------------------------------------------------
   int m_x[2], m_y[2], m_c[2], m_dx[2], m_dy[2];
   int p_x[2], p_y[2], p_bx[2], p_by[2];
   int e_done, e_bnc[2], e_cor[2];
   int busy_left;

   function automatic void move(input int p, input int d, input int st, input int lim,
                                output int np, output int nd, output int b);
      np = p; nd = d; b = 0;
      if (st != 0) begin
         if (d > 0) begin
            if (p + st >= lim) begin np = lim; nd = -1; b = 1; end
            else np = p + st;
         end else begin
            if (p <= st) begin np = 0; nd = 1; b = 1; end
            else np = p - st;
         end
      end
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_x[0] = 100; m_y[0] = 60;
         m_x[1] = 575; m_y[1] = 447;
         for (int i = 0; i < 2; i++) begin
            m_c[i] = 0; m_dx[i] = 1; m_dy[i] = 1;
            e_bnc[i] = 0; e_cor[i] = 0;
         end
         e_done = 0; busy_left = 0;
      end else begin
         e_done = 0;
         for (int i = 0; i < 2; i++) begin e_bnc[i] = 0; e_cor[i] = 0; end
         if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) begin
               e_done = 1;
               for (int i = 0; i < 2; i++) begin
                  m_x[i] = p_x[i];
                  m_y[i] = p_y[i];
                  if (p_bx[i] != 0 || p_by[i] != 0) m_c[i] = (m_c[i] + 1) % 8;
                  e_bnc[i] = (p_bx[i] != 0 || p_by[i] != 0) ? 1 : 0;
                  e_cor[i] = (p_bx[i] != 0 && p_by[i] != 0) ? 1 : 0;
               end
            end
         end else if (frame_start === 1'b1 && pause === 1'b0) begin
            for (int i = 0; i < 2; i++) begin
               move(m_x[i], m_dx[i], int'(speed), MAX_X, p_x[i], m_dx[i], p_bx[i]);
               move(m_y[i], m_dy[i], int'(speed), MAX_Y, p_y[i], m_dy[i], p_by[i]);
            end
            busy_left = 3;
         end
      end
   end

   task automatic cmp_inst(input int i, input logic [9:0] x, input logic [9:0] y,
                           input logic [2:0] c, input logic d, input logic b,
                           input logic k, input logic bs);
      string p;
      p = (i == 0) ? "a" : "b";
      check({p, ".logo_x"},      {22'd0, x},  m_x[i]);
      check({p, ".logo_y"},      {22'd0, y},  m_y[i]);
      check({p, ".color_idx"},   {29'd0, c},  m_c[i]);
      check({p, ".update_done"}, {31'd0, d},  e_done);
      check({p, ".bounce"},      {31'd0, b},  e_bnc[i]);
      check({p, ".corner"},      {31'd0, k},  e_cor[i]);
      check({p, ".busy"},        {31'd0, bs}, (busy_left > 0) ? 1 : 0);
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      cmp_inst(0, a_x, a_y, a_c, a_done, a_bnc, a_cor, a_busy);
      cmp_inst(1, b_x, b_y, b_c, b_done, b_bnc, b_cor, b_busy);
   end

   // ------------------------------------------------------------------
   // Stimulus: inputs change 1 time unit after the rising edge.
   // ------------------------------------------------------------------
   task automatic cyc(input logic fs, input logic ps, input logic [2:0] sp);
      frame_start = fs; pause = ps; speed = sp;
      @(posedge clk); #1;
   endtask

   // Leaves the bench in the cycle where the update becomes visible.
   // Mid-update inputs are random to show they are ignored.
   task automatic do_frame(input logic [2:0] sp);
      cyc(1'b1, 1'b0, sp);
      repeat (3) cyc(1'($urandom), 1'($urandom), 3'($urandom));
   endtask

   initial begin
      int  bc, dc, prev, act_flag;
      bit  wrapped;

      rst = 1'b1; frame_start = 1'b0; pause = 1'b0; speed = 3'd0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset values
      check("rst_a_x", {22'd0, a_x}, 100);
      check("rst_a_y", {22'd0, a_y}, 60);
      check("rst_a_c", {29'd0, a_c}, 0);
      check("rst_b_x", {22'd0, b_x}, 575);
      check("rst_a_busy", {31'd0, a_busy}, 0);

      // First frame, speed 3, with busy length measured
      bc = 0;
      cyc(1'b1, 1'b0, 3'd3);
      repeat (3) begin
         if (a_busy) bc++;
         cyc(1'b0, 1'b0, 3'd0);
      end
      check("busy_cycles", bc, 3);
      check("f1_a_busy", {31'd0, a_busy}, 0);
      check("f1_a_done", {31'd0, a_done}, 1);
      check("f1_a_x", {22'd0, a_x}, 103);
      check("f1_a_y", {22'd0, a_y}, 63);
      check("f1_a_bounce", {31'd0, a_bnc}, 0);
      check("f1_b_x", {22'd0, b_x}, 576);
      check("f1_b_y", {22'd0, b_y}, 448);
      check("f1_b_corner", {31'd0, b_cor}, 1);
      check("f1_b_bounce", {31'd0, b_bnc}, 1);
      check("f1_b_c", {29'd0, b_c}, 1);

      // Walk a to x=574 (y bounces off the bottom on the way), then hit x edge
      repeat (67) do_frame(3'd7);
      do_frame(3'd2);
      check("walk_a_x", {22'd0, a_x}, 574);
      check("walk_a_y", {22'd0, a_y}, 362);
      check("walk_a_c", {29'd0, a_c}, 1);
      do_frame(3'd4);
      check("edge_a_x", {22'd0, a_x}, 576);
      check("edge_a_bounce", {31'd0, a_bnc}, 1);
      check("edge_a_c", {29'd0, a_c}, 2);
      do_frame(3'd4);
      check("after_edge_a_x", {22'd0, a_x}, 572);
      check("after_edge_a_y", {22'd0, a_y}, 354);

      // Paused frame_start does nothing
      act_flag = 0;
      cyc(1'b1, 1'b1, 3'd5);
      repeat (5) begin
         if (a_busy || a_done) act_flag = 1;
         cyc(1'b0, 1'b0, 3'd0);
      end
      check("pause_activity", act_flag, 0);
      check("pause_a_x", {22'd0, a_x}, 572);

      // Second frame_start while busy is ignored
      dc = 0;
      cyc(1'b1, 1'b0, 3'd3);
      cyc(1'b1, 1'b0, 3'd6);
      repeat (8) begin
         if (a_done) dc++;
         cyc(1'b0, 1'b0, 3'd0);
      end
      check("single_update", dc, 1);
      check("dbl_a_x", {22'd0, a_x}, 569);
      check("dbl_a_y", {22'd0, a_y}, 351);

      // Zero speed: pulse without motion
      do_frame(3'd0);
      check("zero_done", {31'd0, a_done}, 1);
      check("zero_bounce", {31'd0, a_bnc}, 0);
      check("zero_a_x", {22'd0, a_x}, 569);
      check("zero_a_y", {22'd0, a_y}, 351);
      check("zero_a_c", {29'd0, a_c}, 2);

      // Random traffic
      repeat (300) cyc(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0), 3'($urandom));
      repeat (4) cyc(1'b0, 1'b0, 3'd0);

      // Colour wrap 7 -> 0 on instance a
      wrapped = 1'b0;
      for (int k = 0; k < 4000 && !wrapped; k++) begin
         prev = m_c[0];
         do_frame(3'($urandom_range(1, 7)));
         if (prev == 7 && m_c[0] == 0) begin
            check("color_wrap", {29'd0, a_c}, 0);
            wrapped = 1'b1;
         end
      end
      if (!wrapped) check("color_wrap_timeout", 0, 1);

      // Reset in the middle of an update
      cyc(1'b1, 1'b0, 3'd5);
      cyc(1'b0, 1'b0, 3'd0);
      rst = 1'b1;
      #1;
      check("midrst_a_x", {22'd0, a_x}, 100);
      check("midrst_a_y", {22'd0, a_y}, 60);
      check("midrst_a_c", {29'd0, a_c}, 0);
      check("midrst_a_busy", {31'd0, a_busy}, 0);
      check("midrst_b_y", {22'd0, b_y}, 447);
      @(posedge clk); #1;
      rst = 1'b0;
      dc = 0;
      repeat (8) begin
         if (a_done || b_done) dc++;
         cyc(1'b0, 1'b0, 3'd0);
      end
      check("midrst_no_done", dc, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
